// File: rtl/key_result_arbiter.sv
// Result collector for the multi-core RC4 key search: rotates candidate keys on the
// display while searching, then latches the winning key or flags global exhaustion.
module key_result_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24,
  parameter int DWELL     = 1,
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]     core_found,
  input  logic [NUM_CORES-1:0]     core_exhausted,
  output logic [KEY_W-1:0]         key_out,
  output logic [IDX_W-1:0]         key_src,
  output logic                     stop_search,
  output logic                     key_valid,
  output logic                     search_failed
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {SCAN, FOUND, FAILED} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DW_W-1:0]      dwell_q, dwell_d;
  logic [NUM_CORES-1:0] exh_q, exh_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic                 stop_q, stop_d;
  logic                 valid_q, valid_d;
  logic                 failed_q, failed_d;
  logic [IDX_W-1:0]     winner;

  // Lowest-index found core wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    winner = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dwell_d  = dwell_q;
    exh_d    = exh_q;
    key_d    = key_q;
    src_d    = src_q;
    stop_d   = stop_q;
    valid_d  = valid_q;
    failed_d = failed_q;
    if (state_q == SCAN) begin
      exh_d = exh_q | core_exhausted;
      if (|core_found) begin
        key_d   = core_key[int'(winner)*KEY_W +: KEY_W];
        src_d   = winner;
        stop_d  = 1'b1;
        valid_d = 1'b1;
        state_d = FOUND;
      end else if (&(exh_q | core_exhausted)) begin
        key_d    = '0;
        src_d    = '0;
        stop_d   = 1'b1;
        failed_d = 1'b1;
        state_d  = FAILED;
      end else begin
        key_d = core_key[int'(ptr_q)*KEY_W +: KEY_W];
        src_d = ptr_q;
        if (dwell_q == DW_W'(DWELL - 1)) begin
          dwell_d = '0;
          // Explicit wrap so non-power-of-two core counts never index past the last core.
          ptr_d   = (ptr_q == IDX_W'(NUM_CORES - 1)) ? '0 : ptr_q + IDX_W'(1);
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SCAN;
      ptr_q    <= '0;
      dwell_q  <= '0;
      exh_q    <= '0;
      key_q    <= '0;
      src_q    <= '0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dwell_q  <= dwell_d;
      exh_q    <= exh_d;
      key_q    <= key_d;
      src_q    <= src_d;
      stop_q   <= stop_d;
      valid_q  <= valid_d;
      failed_q <= failed_d;
    end
  end

  assign key_out       = key_q;
  assign key_src       = src_q;
  assign stop_search   = stop_q;
  assign key_valid     = valid_q;
  assign search_failed = failed_q;

endmodule

// File: tb/tb_key_result_arbiter.sv
// Bench for key_result_arbiter: vector table, rotation sequences, and random traffic
// compared against a cycle-count based reference model.
module tb_key_result_arbiter;

  localparam int NA = 4;
  localparam int DA = 3;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NA*24-1:0] core_key;
  logic [NA-1:0] core_found, core_exhausted;
  logic [23:0]   key_out;
  logic [1:0]    key_src;
  logic          stop_search, key_valid, search_failed;

  logic          b_reset;
  logic [NB*24-1:0] b_key;
  logic [NB-1:0] b_found, b_exh;
  logic [23:0]   b_key_out;
  logic [1:0]    b_key_src;
  logic          b_stop, b_valid, b_failed;

  always #5 clk = ~clk;

  key_result_arbiter #(.NUM_CORES(NA), .KEY_W(24), .DWELL(DA)) dut_a (
    .clk(clk), .reset(reset), .core_key(core_key), .core_found(core_found),
    .core_exhausted(core_exhausted), .key_out(key_out), .key_src(key_src),
    .stop_search(stop_search), .key_valid(key_valid), .search_failed(search_failed)
  );

  key_result_arbiter #(.NUM_CORES(NB), .KEY_W(24), .DWELL(1)) dut_b (
    .clk(clk), .reset(b_reset), .core_key(b_key), .core_found(b_found),
    .core_exhausted(b_exh), .key_out(b_key_out), .key_src(b_key_src),
    .stop_search(b_stop), .key_valid(b_valid), .search_failed(b_failed)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: display position derived from cycles elapsed since reset release.
  int          m_t;
  int          m_mode;   // 0 searching, 1 found, 2 failed
  logic [NA-1:0] m_exh;
  logic [23:0] m_key;
  int          m_src;

  task automatic model_step(input logic r, input logic [NA-1:0] f, input logic [NA-1:0] e,
                            input logic [NA*24-1:0] k);
    int w;
    if (r) begin
      m_t = 0; m_mode = 0; m_exh = '0; m_key = '0; m_src = 0;
    end else if (m_mode == 0) begin
      if (f != 0) begin
        w = 0;
        for (int i = NA - 1; i >= 0; i--) if (f[i]) w = i;
        m_key = k[w*24 +: 24]; m_src = w; m_mode = 1;
      end else if ((m_exh | e) == {NA{1'b1}}) begin
        m_key = '0; m_src = 0; m_mode = 2;
      end else begin
        m_src = (m_t / DA) % NA;
        m_key = k[m_src*24 +: 24];
        m_t++;
      end
      m_exh = m_exh | e;
    end
  endtask

  task automatic apply(input logic r, input logic [NA-1:0] f, input logic [NA-1:0] e,
                       input logic [NA*24-1:0] k);
    reset = r; core_found = f; core_exhausted = e; core_key = k;
    model_step(r, f, e, k);
    @(posedge clk); #1;
    chk("model key_out", key_out, m_key);
    chk("model key_src", key_src, m_src);
    chk("model stop_search", stop_search, m_mode != 0);
    chk("model key_valid", key_valid, m_mode == 1);
    chk("model search_failed", search_failed, m_mode == 2);
  endtask

  typedef struct {
    logic          rst;
    logic [NA-1:0] found;
    logic [NA-1:0] exh;
    logic [NA*24-1:0] keys;
    logic [23:0]   e_key;
    logic [1:0]    e_src;
    logic [2:0]    e_flags;  // {stop_search, key_valid, search_failed}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [NA-1:0] f, input logic [NA-1:0] e,
                     input logic [NA*24-1:0] k, input logic [23:0] ek, input logic [1:0] es,
                     input logic [2:0] ef);
    vec_t v;
    v.rst = r; v.found = f; v.exh = e; v.keys = k; v.e_key = ek; v.e_src = es; v.e_flags = ef;
    tbl.push_back(v);
  endtask

  localparam logic [NA*24-1:0] K_BASE = {24'h123456, 24'h222222, 24'h0ABCDE, 24'hC0FFEE};
  localparam logic [NA*24-1:0] K_ALT  = {24'h999999, 24'h222222, 24'h0ABCDE, 24'hC0FFEE};
  localparam logic [NA*24-1:0] K_TIE  = {24'h3FFFFF, 24'h222222, 24'h0ABCDE, 24'hC0FFEE};

  initial begin
    logic [NA*24-1:0] k;
    logic [NA-1:0] f, e;
    logic r;
    int exp_src_seq[13];
    int bs;

    reset = 1'b1; core_found = '0; core_exhausted = '0; core_key = '0;
    b_reset = 1'b1; b_key = '0; b_found = '0; b_exh = '0;
    m_t = 0; m_mode = 0; m_exh = '0; m_key = '0; m_src = 0;
    @(posedge clk); #1;

    add(1, 4'b0000, 4'b0000, K_BASE, 24'h000000, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'h0ABCDE, 1, 3'b000);
    add(0, 4'b1010, 4'b0000, K_BASE, 24'h0ABCDE, 1, 3'b110);
    add(0, 4'b1000, 4'b0000, K_ALT,  24'h0ABCDE, 1, 3'b110);
    add(1, 4'b0000, 4'b0000, K_BASE, 24'h000000, 0, 3'b000);
    add(0, 4'b0000, 4'b0001, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0100, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0010, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'h0ABCDE, 1, 3'b000);
    add(0, 4'b0000, 4'b1000, K_BASE, 24'h000000, 0, 3'b101);
    add(0, 4'b0001, 4'b0000, K_BASE, 24'h000000, 0, 3'b101);
    add(1, 4'b0000, 4'b0000, K_BASE, 24'h000000, 0, 3'b000);
    add(0, 4'b0000, 4'b0111, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b1000, 4'b1000, K_TIE,  24'h3FFFFF, 3, 3'b110);
    add(1, 4'b0000, 4'b0000, K_BASE, 24'h000000, 0, 3'b000);
    add(0, 4'b0000, 4'b0001, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'hC0FFEE, 0, 3'b000);
    add(0, 4'b0000, 4'b0000, K_BASE, 24'h0ABCDE, 1, 3'b000);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].found, tbl[i].exh, tbl[i].keys);
      chk($sformatf("vec%0d key_out", i), key_out, tbl[i].e_key);
      chk($sformatf("vec%0d key_src", i), key_src, tbl[i].e_src);
      chk($sformatf("vec%0d flags", i), {stop_search, key_valid, search_failed}, tbl[i].e_flags);
    end

    // Rotation with live keys: core i presents 0x10000*i + cycle.
    exp_src_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    apply(1, '0, '0, '0);
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < NA; i++) k[i*24 +: 24] = 24'(24'h10000 * i + c);
      apply(0, '0, '0, k);
      chk($sformatf("rot%0d key_src", c), key_src, exp_src_seq[c]);
      chk($sformatf("rot%0d key_out", c), key_out, 24'(24'h10000 * exp_src_seq[c] + c));
      chk($sformatf("rot%0d flags", c), {stop_search, key_valid, search_failed}, 3'b000);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NA; i++) k[i*24 +: 24] = 24'($urandom);
      r = ($urandom_range(0, 59) == 0);
      f = ($urandom_range(0, 39) == 0) ? NA'($urandom_range(1, 15)) : '0;
      e = ($urandom_range(0, 9) == 0) ? NA'(1 << $urandom_range(0, NA - 1)) : '0;
      apply(r, f, e, k);
    end

    // Three-core instance, one-cycle dwell: explicit wrap 0,1,2,0.
    reset = 1'b1;
    b_reset = 1'b1;
    @(posedge clk); #1;
    chk("b reset key_src", b_key_src, 0);
    chk("b reset key_out", b_key_out, 0);
    b_reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NB; i++) b_key[i*24 +: 24] = 24'($urandom);
      k[NB*24-1:0] = b_key;
      @(posedge clk); #1;
      bs = c % NB;
      chk($sformatf("b%0d key_src", c), b_key_src, bs);
      chk($sformatf("b%0d key_out", c), b_key_out, k[bs*24 +: 24]);
      chk($sformatf("b%0d flags", c), {b_stop, b_valid, b_failed}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_result_arbiter.md
# key_result_arbiter

Parametrised result collector for the multi-core RC4 key search. It sits between NUM_CORES key-search cores and the HEX display driver. While the search runs, it rotates the displayed key through every core's current candidate with a programmable dwell time. When a core reports a match, it selects a winner (lowest index), latches that key and broadcasts stop. It also detects and flags global search failure once every core has exhausted its key range.

## Interface
- NUM_CORES, default 4: number of search cores; legal range 1..16.
- KEY_W, default 24: secret-key width in bits.
- DWELL, default 1: clock cycles each core's key stays on display during rotation; must be ≥1.
- IDX_W, derived as max(1, $clog2(NUM_CORES)): width of the core index.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- core_key  in  NUM_CORES*KEY_W  packed candidate keys; core i occupies bits [i*KEY_W +: KEY_W].
- core_found  in  NUM_CORES  bit i high = core i's current key decrypted correctly (pulse or level).
- core_exhausted  in  NUM_CORES  bit i high = core i searched its whole range without success (pulse or level).
- key_out  out  KEY_W  key to display.
- key_src  out  IDX_W  index of the core whose key is on key_out.
- stop_search  out  1  broadcast stop to all cores.
- key_valid  out  1  high once a correct key is latched.
- search_failed  out  1  high once all cores are exhausted with no match.

## Operation
- States: SCAN, FOUND, FAILED. Reset state is SCAN.
- Internal state:
  - ptr (IDX_W): rotation pointer.
  - dwell_cnt: counts 0..DWELL-1.
  - exh_mask (NUM_CORES): sticky record of core_exhausted.
- Event evaluation order, each cycle in SCAN:
  1. If any core_found bit is set: winner = lowest set index. key_out <= core_key[winner], key_src <= winner, stop_search <= 1, key_valid <= 1, go to FOUND.
  2. Else, if (exh_mask | core_exhausted) is all ones: key_out <= 0, key_src <= 0, stop_search <= 1, search_failed <= 1, go to FAILED.
  3. Else rotate: key_out <= core_key[ptr], key_src <= ptr.
     - If dwell_cnt == DWELL-1: dwell_cnt <= 0, ptr <= ptr+1, wrapping from NUM_CORES-1 to 0.
     - Otherwise dwell_cnt <= dwell_cnt+1.
- exh_mask <= exh_mask | core_exhausted every cycle in SCAN.
- FOUND and FAILED are terminal until reset. All outputs hold. Further core_found or core_exhausted activity is ignored, including a different core's key.
- core_found takes priority over exhaustion in the same cycle. This includes a core asserting found and exhausted together on its final key.
- ptr never takes values ≥ NUM_CORES. When NUM_CORES is not a power of two, the wrap is explicit, not modular on IDX_W.
- NUM_CORES=1: ptr stays 0, and the display shows core 0 continuously.

## Timing
- Reset values:
  - key_out = 0, key_src = 0.
  - stop_search = 0, key_valid = 0, search_failed = 0.
  - ptr = 0, dwell_cnt = 0, exh_mask = 0, state SCAN.
- Reset mid-search or in FOUND/FAILED restores all reset values on the next edge. Reset has priority over all events in that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Found latency: core_found sampled at edge N gives key_out, key_src, stop_search and key_valid valid after edge N. key_out carries the core_key value sampled at edge N.
- Failure latency: the last missing exhausted bit sampled at edge N gives search_failed and stop_search high after edge N.
- Rotation:
  - The first rotating update is at the first edge after reset release, and shows core 0.
  - Each core is shown for exactly DWELL consecutive cycles.
  - Full period is NUM_CORES*DWELL cycles.
  - While a core is shown, key_out is refreshed every cycle, so it tracks that core's changing candidate.
- stop_search, key_valid and search_failed are never deasserted except by reset. key_valid and search_failed are mutually exclusive.

## Test plan
- Rotation, NUM_CORES=4, DWELL=3, core i key = 24'h10000*i+cycle, no found: key_src sequence is 0,0,0,1,1,1,2,2,2,3,3,3,0. key_out equals the live core_key[key_src] each cycle. All flags stay 0.
- Simultaneous found, core_found=4'b1010 for one cycle, core1 key 24'h0ABCDE, core3 key 24'h123456: next cycle key_out=24'h0ABCDE, key_src=1, stop_search=1, key_valid=1. A later core_found=4'b1000 pulse leaves outputs unchanged.
- Staggered exhaustion pulses: core_exhausted pulses on 4'b0001, 4'b0100, 4'b0010, then 4'b1000. search_failed=1 and stop_search=1 one cycle after the last pulse, with key_out=0 and key_valid=0. search_failed is not raised before the last pulse.
- Found versus exhaustion tie: exh_mask=4'b0111, then core_exhausted=4'b1000 and core_found=4'b1000 in the same cycle with core3 key 24'h3FFFFF. Result: key_valid=1, key_out=24'h3FFFFF, search_failed=0.
- Reset mid-operation: assert reset for one cycle while in FOUND. Next cycle all outputs are 0 and state is SCAN. Rotation restarts at key_src=0, and exh_mask is cleared, so a single exhaustion pulse does not fail the search.
- Non-power-of-two, NUM_CORES=3, DWELL=1: key_src cycles 0,1,2,0 and never reaches 3.
